// File: rtl/ksched_pkg.sv
// Shared types and defaults for the time-slot key scheduler.
package ksched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ksched_state_e;

  localparam int KSCHED_KEY_W    = 7;
  localparam int KSCHED_NUM_KEYS = 2;
  localparam int KSCHED_SLOT_LEN = 2;

  // Last phase value before the counter returns to zero.
  function automatic int wrap_value(input int num_keys, input int slot_len);
    return num_keys * slot_len - 1;
  endfunction

endpackage

// File: rtl/ksched_slot_counter.sv
// Free-running phase counter with clear/enable and wrap; derives the slot
// index and the first-cycle-of-slot flag from the registered count.
module ksched_slot_counter
  import ksched_pkg::*;
#(
  parameter int NUM_KEYS = KSCHED_NUM_KEYS,
  parameter int SLOT_LEN = KSCHED_SLOT_LEN,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  parameter int CNT_W    = (NUM_KEYS * SLOT_LEN > 1) ? $clog2(NUM_KEYS * SLOT_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic [IDX_W-1:0] slot_idx_o,
  output logic             slot_start_o
);

  localparam logic [CNT_W-1:0] WRAP = CNT_W'(wrap_value(NUM_KEYS, SLOT_LEN));

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == WRAP) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign slot_idx_o   = IDX_W'(32'(count_q) / SLOT_LEN);
  assign slot_start_o = ((32'(count_q) % SLOT_LEN) == 0);

endmodule

// File: rtl/cute_lock_key_scheduler.sv
// Key bank + IDLE/RUN/PAUSE control presenting one key per time slot.
// Optional KSCHED_ZEROIZE_EN adds a zeroize input that wipes bank, mask and counter.
module cute_lock_key_scheduler
  import ksched_pkg::*;
#(
  parameter int KEY_W    = KSCHED_KEY_W,
  parameter int NUM_KEYS = KSCHED_NUM_KEYS,
  parameter int SLOT_LEN = KSCHED_SLOT_LEN,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  parameter int CNT_W    = (NUM_KEYS * SLOT_LEN > 1) ? $clog2(NUM_KEYS * SLOT_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef KSCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [KEY_W-1:0]    cfg_key,
  input  logic                start,
  input  logic                stop,
  output logic [KEY_W-1:0]    key_out,
  output logic [IDX_W-1:0]    slot_idx,
  output logic [CNT_W-1:0]    counter,
  output logic                slot_start,
  output logic [NUM_KEYS-1:0] loaded_mask,
  output logic                busy,
  output logic                err
);

  ksched_state_e       state_q;
  logic [KEY_W-1:0]    bank_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded_mask_q;
  logic                err_q;

  logic wipe, cfg_fire, idx_ok, go, cnt_clear, cnt_en, raw_slot_start;

`ifdef KSCHED_ZEROIZE_EN
  assign wipe = zeroize;
`else
  assign wipe = 1'b0;
`endif

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign idx_ok    = (32'(cfg_idx) < NUM_KEYS);
  // Start is judged against the registered mask, so a same-cycle write does not count.
  assign go        = (state_q == IDLE) && start && !stop && (&loaded_mask_q);
  assign cnt_clear = go || wipe;
  assign cnt_en    = (state_q == RUN) && !stop;

  ksched_slot_counter #(
    .NUM_KEYS(NUM_KEYS),
    .SLOT_LEN(SLOT_LEN),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_slot_counter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (cnt_clear),
    .en_i        (cnt_en),
    .count_o     (counter),
    .slot_idx_o  (slot_idx),
    .slot_start_o(raw_slot_start)
  );

  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      state_q       <= IDLE;
      loaded_mask_q <= '0;
      err_q         <= 1'b0;
      // NOTE: the key bank is reset explicitly; stale keys must never survive a reset.
      for (int i = 0; i < NUM_KEYS; i++) bank_q[i] <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (&loaded_mask_q) state_q <= RUN;
            else                err_q   <= 1'b1;
          end
        end
        RUN:     if (stop) state_q <= PAUSE;
        PAUSE:   if (start && !stop) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
      if (cfg_fire) begin
        if (idx_ok) begin
          bank_q[cfg_idx]        <= cfg_key;
          loaded_mask_q[cfg_idx] <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign cfg_ready   = (state_q != RUN);
  assign key_out     = busy ? bank_q[slot_idx] : '0;
  assign slot_start  = busy && raw_slot_start;
  assign loaded_mask = loaded_mask_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cute_lock_key_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// slot-arithmetic reference model.
module tb_cute_lock_key_scheduler;

  localparam int KEY_W = 7;
  localparam int N     = 2;
  localparam int S     = 2;
  localparam int IDX_W = 1;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, cfg_valid, start, stop;
  logic [IDX_W-1:0] cfg_idx;
  logic [KEY_W-1:0] cfg_key;
`ifdef KSCHED_ZEROIZE_EN
  logic             zeroize = 1'b0;
`endif
  logic             cfg_ready, slot_start, busy, err;
  logic [KEY_W-1:0] key_out;
  logic [IDX_W-1:0] slot_idx;
  logic [CNT_W-1:0] counter;
  logic [N-1:0]     loaded_mask;

  cute_lock_key_scheduler dut (
    .clk        (clk),
    .rst        (rst),
`ifdef KSCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idx    (cfg_idx),
    .cfg_key    (cfg_key),
    .start      (start),
    .stop       (stop),
    .key_out    (key_out),
    .slot_idx   (slot_idx),
    .counter    (counter),
    .slot_start (slot_start),
    .loaded_mask(loaded_mask),
    .busy       (busy),
    .err        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_e;
  mode_e    m_mode;
  int       m_phase;
  int       m_bank [N];
  bit [N-1:0] m_mask;
  bit       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a phase in 0..N*S-1 selects key phase/S while running.
  function automatic void model_update();
    bit wipe;
    bit wr;
    wipe = rst;
`ifdef KSCHED_ZEROIZE_EN
    if (zeroize) wipe = 1'b1;
`endif
    if (wipe) begin
      m_mode  = M_IDLE;
      m_phase = 0;
      m_mask  = '0;
      m_err   = 1'b0;
      for (int i = 0; i < N; i++) m_bank[i] = 0;
      return;
    end
    m_err = 1'b0;
    wr    = cfg_valid && (m_mode != M_RUN);
    case (m_mode)
      M_IDLE: if (start && !stop) begin
        if (m_mask == '1) begin
          m_mode  = M_RUN;
          m_phase = 0;
        end else begin
          m_err = 1'b1;
        end
      end
      M_RUN:   if (stop) m_mode = M_PAUSE; else m_phase = (m_phase + 1) % (N * S);
      M_PAUSE: if (start && !stop) m_mode = M_RUN;
    endcase
    if (wr) begin
      if (int'(cfg_idx) < N) begin
        m_bank[cfg_idx] = int'(cfg_key);
        m_mask[cfg_idx] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endfunction

  task automatic check_all();
    int slot;
    bit run;
    slot = m_phase / S;
    run  = (m_mode == M_RUN);
    check("busy",        busy,        run);
    check("cfg_ready",   cfg_ready,   !run);
    check("counter",     counter,     m_phase);
    check("slot_idx",    slot_idx,    slot);
    check("key_out",     key_out,     run ? m_bank[slot] : 0);
    check("slot_start",  slot_start,  run && (m_phase % S == 0));
    check("loaded_mask", loaded_mask, m_mask);
    check("err",         err,         m_err);
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit v,
                      input int idx, input int key);
    rst       = r;
    start     = s;
    stop      = p;
    cfg_valid = v;
    cfg_idx   = IDX_W'(idx);
    cfg_key   = KEY_W'(key);
    @(posedge clk);
    model_update();
    #1 check_all();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_key [5] = '{95, 95, 18, 18, 95};
    int exp_cnt [5] = '{0, 1, 2, 3, 0};

    step(1, 0, 0, 0, 0, 0);
    check("reset_key_out", key_out, 0);
    check("reset_ready",   cfg_ready, 1);

    // Only key0 loaded: start must be rejected.
    step(0, 0, 0, 1, 0, 95);
    step(0, 1, 0, 0, 0, 0);
    check("partial_err",  err, 1);
    check("partial_busy", busy, 0);
    check("partial_key",  key_out, 0);

    // Full bank: key sequence 95,95,18,18,95.
    step(0, 0, 0, 1, 1, 18);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) idle_step();
      check("seq_key", key_out, exp_key[i]);
      check("seq_cnt", counter, exp_cnt[i]);
      check("seq_slot_start", slot_start, (exp_cnt[i] % S) == 0);
    end

    // Pause at counter 2, reload key1, resume.
    idle_step();
    idle_step();
    step(0, 0, 1, 0, 0, 0);
    check("pause_cnt", counter, 2);
    check("pause_key", key_out, 0);
    step(0, 0, 0, 1, 1, 5);
    step(0, 1, 0, 0, 0, 0);
    check("resume_key0", key_out, 5);
    idle_step();
    check("resume_key1", key_out, 5);
    idle_step();
    check("resume_key2", key_out, 95);

    // start+stop together in RUN at counter 1: stop wins.
    idle_step();
    step(0, 1, 1, 0, 0, 0);
    check("ss_busy", busy, 0);
    check("ss_cnt",  counter, 1);

    // Reset at counter 3 clears mask; a later start is rejected.
    step(0, 1, 0, 0, 0, 0);
    idle_step();
    idle_step();
    check("pre_rst_cnt", counter, 3);
    step(1, 0, 0, 0, 0, 0);
    check("rst_mask", loaded_mask, 0);
    check("rst_key",  key_out, 0);
    step(0, 1, 0, 0, 0, 0);
    check("rst_start_err", err, 1);

`ifdef KSCHED_ZEROIZE_EN
    step(0, 0, 0, 1, 0, 33);
    step(0, 0, 0, 1, 1, 44);
    step(0, 1, 0, 0, 0, 0);
    zeroize = 1'b1;
    step(0, 0, 0, 1, 1, 77);
    zeroize = 1'b0;
    check("zero_mask", loaded_mask, 0);
    check("zero_busy", busy, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, 127)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cute_lock_key_scheduler.md
Name: cute_lock_key_scheduler

Overview:
Time-slot key scheduler for counter-gated locked FSMs. Holds a bank of NUM_KEYS keys and presents one key per slot on key_out, cycling through the slots on a free-running phase counter. A locked FSM's state-advance gate compares key_out against its embedded slot keys. Sits between the key-load/config path and the locked core; key_out is all-zero whenever the scheduler is not running (fail-safe wrong key).

Parameters:
KEY_W, 7, width of each key
NUM_KEYS, 2, number of key slots in the bank
SLOT_LEN, 2, cycles each key is held on key_out
IDX_W, $clog2(NUM_KEYS) (min 1), width of key index
CNT_W, $clog2(NUM_KEYS*SLOT_LEN) (min 1), width of phase counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
cfg_valid  in  1  key write request
cfg_ready  out  1  key write accepted when valid&ready
cfg_idx  in  IDX_W  bank index to write
cfg_key  in  KEY_W  key value
start  in  1  run/resume request (level sampled each cycle)
stop  in  1  pause request
key_out  out  KEY_W  current slot key
slot_idx  out  IDX_W  current slot index
counter  out  CNT_W  phase counter
slot_start  out  1  high on the first cycle of each slot
loaded_mask  out  NUM_KEYS  bit i set once key i is written
busy  out  1  high in RUN
err  out  1  one-cycle pulse: start rejected

Behaviour:
- States: IDLE, RUN, PAUSE. Reset -> IDLE.
- Reset values: counter=0, slot_idx=0, key_out=0, loaded_mask=0, bank=0, busy=0, err=0, slot_start=0, cfg_ready=1.
- cfg_ready=1 in IDLE and PAUSE, 0 in RUN. On accepted write: bank[cfg_idx]<=cfg_key and loaded_mask[cfg_idx]<=1 on the next edge. cfg_idx>=NUM_KEYS: write is ignored, and err pulses.
- IDLE:
  - start with the registered loaded_mask all ones -> RUN, counter=0.
  - start with any bit clear -> stay in IDLE, err pulses.
  - A write in the same cycle as start is not counted toward that start.
- RUN:
  - counter increments every cycle and wraps from NUM_KEYS*SLOT_LEN-1 to 0.
  - slot_idx = counter/SLOT_LEN.
  - key_out = bank[slot_idx], combinational from registered counter and bank, so there is zero-cycle latency from the counter.
  - slot_start = (counter % SLOT_LEN == 0).
- stop in RUN -> PAUSE. counter holds, key_out=0, slot_start=0.
- start in PAUSE -> RUN, resuming from the held counter. Writes in PAUSE take effect when RUN resumes.
- start and stop in the same cycle: stop wins in all states.
- rst mid-RUN: returns to IDLE and clears the bank and mask (keys must be reloaded).
- With NUM_KEYS=2, SLOT_LEN=2: counter 0,1 select key 0 and counter 2,3 select key 1, matching the locked-FSM gate windows (counter<=1, then 2..3).

Optional Feature:
Macro KSCHED_ZEROIZE_EN.
- Defined: adds input zeroize (1 bit). When asserted in any state, the next edge clears the bank, loaded_mask and counter and enters IDLE. zeroize has priority over start, stop and cfg writes.
- Undefined: the port is absent, and the bank is cleared only by rst.

Decomposition:
- Package ksched_pkg: state enum (IDLE, RUN, PAUSE), default KEY_W/NUM_KEYS/SLOT_LEN constants, and a function computing the wrap value NUM_KEYS*SLOT_LEN-1.
- Sub-module ksched_slot_counter: the phase counter with enable/hold/clear and wrap. It also derives slot_idx and slot_start.

Test Plan:
- Write key0=95, key1=18; start -> busy=1. key_out is 95,95,18,18,95... with counter 0,1,2,3,0. slot_start is high at counter 0 and 2.
- Write only key0; start -> err pulse, state stays IDLE, key_out=0, busy=0.
- In RUN at counter=2, assert stop -> counter holds at 2, key_out=0. Write key1=5, then start -> key_out=5 at counter 2, then 5, then 95.
- Assert start and stop together in RUN at counter=1 -> PAUSE, counter holds at 1.
- Assert rst at counter=3 in RUN -> next cycle IDLE, loaded_mask=0, key_out=0. A following start pulses err.
- With KSCHED_ZEROIZE_EN, assert zeroize during a cfg write in RUN -> bank=0, mask=0, IDLE; the write is dropped.
